// File: rtl/reduction_unit.sv
// ============================================================================
// Module   : reduction_unit
// Purpose  : Final RED stage: sums four 5-bit nibble partials, sign-extends
//            from bit 6. Define REDUCTION_PIPE2_EN for a two-stage pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reduction_unit #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       s0,
  input  logic [3:0]       s1,
  input  logic [3:0]       s2,
  input  logic [3:0]       s3,
  input  logic             g0,
  input  logic             g1,
  input  logic             g2,
  input  logic             g3,
  output logic             out_valid,
  output logic [OUT_W-1:0] S_red
);

  logic [4:0]       w_p0;
  logic [4:0]       w_p1;
  logic [4:0]       w_p2;
  logic [4:0]       w_p3;
  logic [6:0]       w_total;
  logic             w_stage_valid;
  logic [OUT_W-1:0] w_result;

  logic [OUT_W-1:0] sred_d;
  logic [OUT_W-1:0] sred_q;
  logic             out_valid_d;
  logic             out_valid_q;

  assign w_p0 = {g0, s0};
  assign w_p1 = {g1, s1};
  assign w_p2 = {g2, s2};
  assign w_p3 = {g3, s3};

`ifdef REDUCTION_PIPE2_EN
  logic [5:0] w_pair01;
  logic [5:0] w_pair23;
  logic [5:0] pair01_d;
  logic [5:0] pair01_q;
  logic [5:0] pair23_d;
  logic [5:0] pair23_q;
  logic       v1_d;
  logic       v1_q;

  assign w_pair01 = {1'b0, w_p0} + {1'b0, w_p1};
  assign w_pair23 = {1'b0, w_p2} + {1'b0, w_p3};

  always_comb begin
    pair01_d = pair01_q;
    pair23_d = pair23_q;
    v1_d     = in_valid;
    if (in_valid) begin
      pair01_d = w_pair01;
      pair23_d = w_pair23;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair01_q <= 6'd0;
      pair23_q <= 6'd0;
      v1_q     <= 1'b0;
    end else begin
      pair01_q <= pair01_d;
      pair23_q <= pair23_d;
      v1_q     <= v1_d;
    end
  end

  assign w_total       = {1'b0, pair01_q} + {1'b0, pair23_q};
  assign w_stage_valid = v1_q;
`else
  assign w_total       = {2'b00, w_p0} + {2'b00, w_p1} + {2'b00, w_p2} + {2'b00, w_p3};
  assign w_stage_valid = in_valid;
`endif

  // Totals of 64 and above intentionally read as negative after extension.
  generate
    if (OUT_W > 7) begin : g_ext
      assign w_result = {{(OUT_W-7){w_total[6]}}, w_total};
    end else begin : g_noext
      assign w_result = w_total;
    end
  endgenerate

  always_comb begin
    sred_d      = sred_q;
    out_valid_d = w_stage_valid;
    if (w_stage_valid) begin
      sred_d = w_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sred_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sred_q      <= sred_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign S_red     = sred_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_reduction_unit.sv
// ============================================================================
// Module   : tb_reduction_unit
// Purpose  : Scoreboard bench for reduction_unit (honours REDUCTION_PIPE2_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reduction_unit;

  localparam int OUT_W = 16;
`ifdef REDUCTION_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [3:0]       s0, s1, s2, s3;
  logic             g0, g1, g2, g3;
  logic             out_valid;
  logic [OUT_W-1:0] S_red;

  logic [OUT_W-1:0] q_exp[$];
  bit               vq[$];
  logic [OUT_W-1:0] last_exp;
  int               n_cmp  = 0;
  int               n_fail = 0;

  reduction_unit #(.OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .s3        (s3),
    .g0        (g0),
    .g1        (g1),
    .g2        (g2),
    .g3        (g3),
    .out_valid (out_valid),
    .S_red     (S_red)
  );

  always #5 clk = ~clk;

  task automatic clear_pipe();
    q_exp.delete();
    vq.delete();
    for (int i = 0; i < LAT - 1; i++) vq.push_back(1'b0);
    last_exp = '0;
  endtask

  // Drive one input cycle, record expectations, return expected out_valid.
  task automatic step(input bit v, input logic [15:0] s_all, input logic [3:0] g_all,
                      input logic [OUT_W-1:0] exp_val, output bit ev);
    @(negedge clk);
    in_valid = v;
    s0 = s_all[3:0];   s1 = s_all[7:4];   s2 = s_all[11:8];  s3 = s_all[15:12];
    g0 = g_all[0];     g1 = g_all[1];     g2 = g_all[2];     g3 = g_all[3];
    if (v) q_exp.push_back(exp_val);
    vq.push_back(v);
    @(posedge clk);
    #1;
    ev = vq.pop_front();
  endtask

  task automatic test_reset();
    n_cmp++;
    if (S_red !== '0) begin
      n_fail++;
      $display("FAIL reset_sred: got %h expected %h", S_red, 16'h0000);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_directed();
    logic [15:0]      t_s[5]   = '{16'h1234, 16'h01FF, 16'h11FF, 16'hFFFF, 16'h0000};
    logic [3:0]       t_g[5]   = '{4'h0, 4'h3, 4'h3, 4'hF, 4'h0};
    logic [OUT_W-1:0] t_e[5]   = '{16'h000A, 16'h003F, 16'hFFC0, 16'hFFFC, 16'h0000};
    string            t_n[5]   = '{"simple", "sign_63", "sign_64", "max_124", "zero"};
    bit               ev;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c <= LAT; c++) begin
        step(c == 0, t_s[k], t_g[k], t_e[k], ev);
        n_cmp++;
        if (out_valid !== ev) begin
          n_fail++;
          $display("FAIL %s_valid cyc%0d: got %b expected %b", t_n[k], c, out_valid, ev);
        end
        if (ev && q_exp.size() > 0) last_exp = q_exp.pop_front();
        n_cmp++;
        if (S_red !== last_exp) begin
          n_fail++;
          $display("FAIL %s_sred cyc%0d: got %h expected %h", t_n[k], c, S_red, last_exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] pat = 5'b0;
    bit         ev;
    logic [15:0] xs;
    for (int c = 0; c < 5 + LAT - 1; c++) begin
      xs = (c == 3) ? 16'hxxxx : 16'($urandom);
      case (c)
        0:       step(1'b1, 16'h1234, 4'h0, 16'h000A, ev);
        1:       step(1'b1, 16'h11FF, 4'h3, 16'hFFC0, ev);
        default: step(1'b0, xs, 4'($urandom), 16'h0000, ev);
      endcase
      if (c >= LAT - 1) pat = {pat[3:0], out_valid};
      n_cmp++;
      if (out_valid !== ev) begin
        n_fail++;
        $display("FAIL b2b_valid cyc%0d: got %b expected %b", c, out_valid, ev);
      end
      if (ev && q_exp.size() > 0) last_exp = q_exp.pop_front();
      n_cmp++;
      if (S_red !== last_exp) begin
        n_fail++;
        $display("FAIL b2b_sred cyc%0d: got %h expected %h", c, S_red, last_exp);
      end
    end
    n_cmp++;
    if (pat !== 5'b11000) begin
      n_fail++;
      $display("FAIL b2b_pattern: got %b expected %b", pat, 5'b11000);
    end
  endtask

  task automatic test_reset_midstream();
    bit ev;
    step(1'b1, 16'hFFFF, 4'hF, 16'hFFFC, ev);
    @(negedge clk);
    in_valid = 1'b1;
    {s3, s2, s1, s0} = 16'h11FF;
    {g3, g2, g1, g0} = 4'h3;
    #2 rst_n = 1'b0;
    #1;
    clear_pipe();
    n_cmp++;
    if (S_red !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: got %h/%b expected 0000/0", S_red, out_valid);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (S_red !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_held: got %h/%b expected 0000/0", S_red, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int c = 0; c <= LAT; c++) begin
      step(c == 0, 16'h1234, 4'h0, 16'h000A, ev);
      n_cmp++;
      if (out_valid !== ev) begin
        n_fail++;
        $display("FAIL postreset_valid cyc%0d: got %b expected %b", c, out_valid, ev);
      end
      if (ev && q_exp.size() > 0) last_exp = q_exp.pop_front();
      n_cmp++;
      if (S_red !== last_exp) begin
        n_fail++;
        $display("FAIL postreset_sred cyc%0d: got %h expected %h", c, S_red, last_exp);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0]      a, b, s_all;
    logic [3:0]       g_all;
    logic [4:0]       ps;
    logic [7:0]       tot;
    logic [OUT_W-1:0] e;
    bit               ev;
    for (int n = 0; n < 100 + LAT; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      tot = 8'd0;
      for (int i = 0; i < 4; i++) begin
        ps = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]};
        s_all[i*4 +: 4] = ps[3:0];
        g_all[i] = ps[4];
        tot = tot + 8'(a[i*4 +: 4]) + 8'(b[i*4 +: 4]);
      end
      e = {{(OUT_W-7){tot[6]}}, tot[6:0]};
      step(n < 100, s_all, g_all, e, ev);
      n_cmp++;
      if (out_valid !== ev) begin
        n_fail++;
        $display("FAIL random_valid #%0d: got %b expected %b", n, out_valid, ev);
      end
      if (ev && q_exp.size() > 0) last_exp = q_exp.pop_front();
      n_cmp++;
      if (S_red !== last_exp) begin
        n_fail++;
        $display("FAIL random_sred #%0d: got %h expected %h", n, S_red, last_exp);
      end
    end
    n_cmp++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d pending expected 0", q_exp.size());
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    {s3, s2, s1, s0} = 16'h0000;
    {g3, g2, g1, g0} = 4'h0;
    clear_pipe();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
